// File: rtl/mem_stage_pkg.sv
// Shared widths, access-size encodings and FSM states for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned STRB = XLEN / 8;

    // funct3 access-size encodings
    typedef enum logic [2:0] {
        MemB  = 3'b000,
        MemH  = 3'b001,
        MemW  = 3'b010,
        MemD  = 3'b011,
        MemBu = 3'b100,
        MemHu = 3'b101,
        MemWu = 3'b110
    } mem_size_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    // Low address bits that must be zero for a naturally aligned access of this size
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        case (size[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane replication / byte strobes and load extract / extend.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      size,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [STRB-1:0] wstrb,
    output logic [XLEN-1:0] load_data
);

    logic [STRB-1:0] mask;
    logic [XLEN-1:0] shifted;

    // Replicate store data across lanes and shift the size mask to the byte offset
    always_comb begin
        wdata = store_data;
        mask  = {STRB{1'b1}};
        case (size[1:0])
            2'b00: begin
                wdata = {STRB{store_data[7:0]}};
                mask  = STRB'(8'h01);
            end
            2'b01: begin
                wdata = {(STRB/2){store_data[15:0]}};
                mask  = STRB'(8'h03);
            end
            2'b10: begin
                wdata = {(STRB/4){store_data[31:0]}};
                mask  = STRB'(8'h0F);
            end
            default: begin
                wdata = store_data;
                mask  = {STRB{1'b1}};
            end
        endcase
        wstrb = mask << offset;
    end

    // Move the addressed bytes to bit 0, then sign- or zero-extend by size
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        load_data = shifted;
        case (size)
            MemB:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MemH:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MemW:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            MemBu:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MemHu:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            MemWu:   load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues load/store over a req/ack handshake, stalls EX while an
// access is outstanding and registers the MEM/WB boundary.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of
// forcing natural alignment.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_mem_rd,
    input  logic            ex_mem_wr,
    input  logic [2:0]      ex_mem_size,
    input  logic [4:0]      ex_rd,
    input  logic            ex_is_write_rf,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [STRB-1:0] dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] fake_write_back_data,
    output logic [4:0]      fake_write_back_addr,
    output logic            fake_is_write_rf,
    output logic            misalign_trap
);

    mem_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [2:0]      size_q, size_d;
    logic [4:0]      rd_q, rd_d;
    logic            is_load_q, is_load_d;
    logic            wrf_q, wrf_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic            wb_we_q, wb_we_d;
    logic            trap_q, trap_d;

    logic            mem_op;
    logic            misaligned;
    logic [XLEN-1:0] eff_addr;
    logic [XLEN-1:0] lane_wdata;
    logic [STRB-1:0] lane_wstrb;
    logic [XLEN-1:0] load_data;

    assign mem_op   = ex_mem_rd | ex_mem_wr;
    // Dropping the sub-size bits is a no-op for aligned addresses
    assign eff_addr = {ex_alu_result[XLEN-1:3],
                       ex_alu_result[2:0] & ~align_mask(ex_mem_size)};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = |(ex_alu_result[2:0] & align_mask(ex_mem_size));
`else
    assign misaligned = 1'b0;
`endif

    mem_align u_align (
        .size       (size_q),
        .offset     (addr_q[2:0]),
        .store_data (sdata_q),
        .rdata      (dmem_rdata),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb),
        .load_data  (load_data)
    );

    // Next-state, request latch, WB register inputs and stall
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        size_d    = size_q;
        rd_d      = rd_q;
        is_load_d = is_load_q;
        wrf_d     = wrf_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        wb_we_d   = 1'b0;
        trap_d    = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (!mem_op) begin
                        wb_data_d = ex_alu_result;
                        wb_addr_d = ex_rd;
                        wb_we_d   = ex_is_write_rf && (ex_rd != 5'd0);
                    end else if (misaligned) begin
                        trap_d = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        addr_d    = eff_addr;
                        sdata_d   = ex_store_data;
                        size_d    = ex_mem_size;
                        rd_d      = ex_rd;
                        is_load_d = ex_mem_rd;
                        wrf_d     = ex_is_write_rf;
                        state_d   = StWait;
                    end
                end
            end
            StWait: begin
                mem_stall = !dmem_ack;
                if (dmem_ack) begin
                    state_d = StIdle;
                    // Stores only clear the WB enable; data/addr hold
                    if (is_load_q) begin
                        wb_data_d = load_data;
                        wb_addr_d = rd_q;
                        wb_we_d   = wrf_q && (rd_q != 5'd0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, request latch and MEM/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            sdata_q   <= '0;
            size_q    <= '0;
            rd_q      <= '0;
            is_load_q <= 1'b0;
            wrf_q     <= 1'b0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_we_q   <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            size_q    <= size_d;
            rd_q      <= rd_d;
            is_load_q <= is_load_d;
            wrf_q     <= wrf_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_we_q   <= wb_we_d;
            trap_q    <= trap_d;
        end
    end

    assign dmem_req             = (state_q == StWait);
    assign dmem_we              = dmem_req & ~is_load_q;
    assign dmem_addr            = {addr_q[XLEN-1:3], 3'b000};
    assign dmem_wdata           = lane_wdata;
    assign dmem_wstrb           = dmem_we ? lane_wstrb : '0;
    assign fake_write_back_data = wb_data_q;
    assign fake_write_back_addr = wb_addr_q;
    assign fake_is_write_rf     = wb_we_q;
    assign misalign_trap        = trap_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected WB results.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [63:0]     ex_alu_result;
    logic [63:0]     ex_store_data;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic [2:0]      ex_mem_size;
    logic [4:0]      ex_rd;
    logic            ex_is_write_rf;
    logic            mem_stall;
    logic            dmem_req;
    logic            dmem_we;
    logic [63:0]     dmem_addr;
    logic [63:0]     dmem_wdata;
    logic [7:0]      dmem_wstrb;
    logic            dmem_ack;
    logic [63:0]     dmem_rdata;
    logic [63:0]     fake_write_back_data;
    logic [4:0]      fake_write_back_addr;
    logic            fake_is_write_rf;
    logic            misalign_trap;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  addr;
        logic        we;
        logic        full;   // compare data/addr too, not only the enable
    } wb_exp_t;

    wb_exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_valid             (ex_valid),
        .ex_alu_result        (ex_alu_result),
        .ex_store_data        (ex_store_data),
        .ex_mem_rd            (ex_mem_rd),
        .ex_mem_wr            (ex_mem_wr),
        .ex_mem_size          (ex_mem_size),
        .ex_rd                (ex_rd),
        .ex_is_write_rf       (ex_is_write_rf),
        .mem_stall            (mem_stall),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_wstrb           (dmem_wstrb),
        .dmem_ack             (dmem_ack),
        .dmem_rdata           (dmem_rdata),
        .fake_write_back_data (fake_write_back_data),
        .fake_write_back_addr (fake_write_back_addr),
        .fake_is_write_rf     (fake_is_write_rf),
        .misalign_trap        (misalign_trap)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid       = 1'b0;
        ex_mem_rd      = 1'b0;
        ex_mem_wr      = 1'b0;
        ex_mem_size    = 3'b000;
        ex_rd          = 5'd0;
        ex_is_write_rf = 1'b0;
        ex_alu_result  = 64'h0;
        ex_store_data  = 64'h0;
    endtask

    // One load/store through the handshake; ack comes after 'delay' WAIT cycles.
    task automatic do_mem(input string name, input logic is_ld, input logic [2:0] size,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [4:0] rd, input logic wrf, input logic [63:0] rdata,
                          input int delay, input logic [63:0] exp_daddr,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                          input logic [63:0] exp_data);
        wb_exp_t e;
        ex_valid       = 1'b1;
        ex_mem_rd      = is_ld;
        ex_mem_wr      = !is_ld;
        ex_mem_size    = size;
        ex_alu_result  = addr;
        ex_store_data  = sdata;
        ex_rd          = rd;
        ex_is_write_rf = wrf;
        e.data = exp_data;
        e.addr = rd;
        e.we   = is_ld && wrf && (rd != 5'd0);
        e.full = is_ld;
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: stall=%b req=%b, required stall=1 req=0", name,
                     mem_stall, dmem_req);
        end
        next_cycle();
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++;
            if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || dmem_addr !== exp_daddr) begin
                errors++;
                $display("FAIL %s wait%0d: stall=%b req=%b addr=%h, required 1 1 %h", name, i,
                         mem_stall, dmem_req, dmem_addr, exp_daddr);
            end
            if (!is_ld) begin
                checks++;
                if (dmem_wdata !== exp_wdata) begin
                    errors++;
                    $display("FAIL %s wait%0d wdata: %h, required %h", name, i, dmem_wdata,
                             exp_wdata);
                end
            end
            next_cycle();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== exp_daddr ||
            dmem_we !== !is_ld) begin
            errors++;
            $display("FAIL %s ack: stall=%b req=%b addr=%h we=%b, required 0 1 %h %b", name,
                     mem_stall, dmem_req, dmem_addr, dmem_we, exp_daddr, !is_ld);
        end
        checks++;
        if (dmem_wstrb !== (is_ld ? 8'h00 : exp_strb) ||
            (!is_ld && dmem_wdata !== exp_wdata)) begin
            errors++;
            $display("FAIL %s lanes: wstrb=%h wdata=%h, required %h %h", name, dmem_wstrb,
                     dmem_wdata, is_ld ? 8'h00 : exp_strb, exp_wdata);
        end
        next_cycle();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        clear_ex();
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req drop: req=%b, required 0", name, dmem_req);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s wb: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (fake_is_write_rf !== e.we ||
                (e.full && (fake_write_back_data !== e.data || fake_write_back_addr !== e.addr)))
            begin
                errors++;
                $display("FAIL %s wb: data=%h addr=%0d we=%b, required %h %0d %b", name,
                         fake_write_back_data, fake_write_back_addr, fake_is_write_rf,
                         e.data, e.addr, e.we);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        clear_ex();
        next_cycle();
        next_cycle();
        checks++;
        if ({mem_stall, dmem_req, dmem_we, dmem_wstrb, misalign_trap} !== 12'h0 ||
            dmem_addr !== 64'h0 || dmem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset dmem: stall=%b req=%b we=%b strb=%h addr=%h wdata=%h, required 0",
                     mem_stall, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata);
        end
        checks++;
        if (fake_write_back_data !== 64'h0 || fake_write_back_addr !== 5'd0 ||
            fake_is_write_rf !== 1'b0) begin
            errors++;
            $display("FAIL reset wb: data=%h addr=%0d we=%b, required 0", fake_write_back_data,
                     fake_write_back_addr, fake_is_write_rf);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        wb_exp_t e;
        ex_valid       = 1'b1;
        ex_alu_result  = 64'h1234;
        ex_rd          = 5'd5;
        ex_is_write_rf = 1'b1;
        sb.push_back('{data: 64'h1234, addr: 5'd5, we: 1'b1, full: 1'b1});
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu stall: %b, required 0", mem_stall);
        end
        next_cycle();
        // rd == 0 must not write back
        ex_alu_result = 64'h55;
        ex_rd         = 5'd0;
        sb.push_back('{data: 64'h55, addr: 5'd0, we: 1'b0, full: 1'b1});
        e = sb.pop_front();
        checks++;
        if (fake_write_back_data !== e.data || fake_write_back_addr !== e.addr ||
            fake_is_write_rf !== e.we || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu wb: data=%h addr=%0d we=%b stall=%b, required %h %0d %b 0",
                     fake_write_back_data, fake_write_back_addr, fake_is_write_rf, mem_stall,
                     e.data, e.addr, e.we);
        end
        next_cycle();
        clear_ex();
        e = sb.pop_front();
        checks++;
        if (fake_write_back_data !== e.data || fake_write_back_addr !== e.addr ||
            fake_is_write_rf !== e.we) begin
            errors++;
            $display("FAIL alu rd0: data=%h addr=%0d we=%b, required %h %0d %b",
                     fake_write_back_data, fake_write_back_addr, fake_is_write_rf,
                     e.data, e.addr, e.we);
        end
        next_cycle();
        checks++;
        if (fake_is_write_rf !== 1'b0 || fake_write_back_data !== 64'h55) begin
            errors++;
            $display("FAIL alu idle hold: we=%b data=%h, required 0 0000000000000055",
                     fake_is_write_rf, fake_write_back_data);
        end
    endtask

    task automatic test_load();
        do_mem("lb", 1'b1, 3'b000, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h00000000_80000000, 1,
               64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        do_mem("lbu", 1'b1, 3'b100, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h00000000_80000000, 0,
               64'h1000, 8'h00, 64'h0, 64'h80);
        do_mem("ld_rd0", 1'b1, 3'b011, 64'h88, 64'h0, 5'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 0,
               64'h88, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_store();
        do_mem("sh", 1'b0, 3'b001, 64'h2006, 64'hBEEF, 5'd3, 1'b0, 64'h0, 0,
               64'h2000, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0);
        do_mem("sb", 1'b0, 3'b000, 64'h5, 64'h1234_56AB, 5'd0, 1'b0, 64'h0, 0,
               64'h0, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 64'h0);
        do_mem("sw", 1'b0, 3'b010, 64'h2004, 64'hFFFF_FFFF_1122_3344, 5'd0, 1'b0, 64'h0, 0,
               64'h2000, 8'hF0, 64'h1122_3344_1122_3344, 64'h0);
    endtask

    task automatic test_delayed_ack();
        do_mem("sd_slow", 1'b0, 3'b011, 64'h3008, 64'hCAFE_F00D_1234_5678, 5'd2, 1'b0, 64'h0,
               5, 64'h3008, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0);
        do_mem("ld_slow", 1'b1, 3'b011, 64'h3010, 64'h0, 5'd11, 1'b1, 64'hA5A5_0000_FFFF_5A5A,
               3, 64'h3010, 8'h00, 64'h0, 64'hA5A5_0000_FFFF_5A5A);
    endtask

    task automatic test_reset_mid_wait();
        ex_valid       = 1'b1;
        ex_mem_rd      = 1'b1;
        ex_mem_size    = 3'b011;
        ex_alu_result  = 64'h4000;
        ex_rd          = 5'd6;
        ex_is_write_rf = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait pre: req=%b, required 1", dmem_req);
        end
        rst = 1'b1;
        clear_ex();
        next_cycle();
        checks++;
        if ({dmem_req, dmem_we, dmem_wstrb, mem_stall, fake_is_write_rf} !== 12'h0 ||
            dmem_addr !== 64'h0 || fake_write_back_data !== 64'h0) begin
            errors++;
            $display("FAIL rst_wait: req=%b we=%b strb=%h addr=%h wb=%h, required all 0",
                     dmem_req, dmem_we, dmem_wstrb, dmem_addr, fake_write_back_data);
        end
        rst = 1'b0;
        next_cycle();
        do_mem("lw_after_rst", 1'b1, 3'b010, 64'h1004, 64'h0, 5'd9, 1'b1,
               64'h80000001_00000000, 0, 64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0001);
    endtask

    task automatic test_back_to_back();
        // ack while idle is ignored
        dmem_ack = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || fake_is_write_rf !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: req=%b stall=%b we=%b, required 0 0 0", dmem_req,
                     mem_stall, fake_is_write_rf);
        end
        next_cycle();
        dmem_ack = 1'b0;
        do_mem("b2b_lh", 1'b1, 3'b001, 64'h10_0002, 64'h0, 5'd12, 1'b1,
               64'h0000_0000_8001_0000, 0, 64'h10_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
        do_mem("b2b_lwu", 1'b1, 3'b110, 64'h10_0004, 64'h0, 5'd13, 1'b1,
               64'hF000_0000_0000_0000, 0, 64'h10_0000, 8'h00, 64'h0, 64'h0000_0000_F000_0000);
        do_mem("b2b_lhu", 1'b1, 3'b101, 64'h10_0006, 64'h0, 5'd14, 1'b1,
               64'h9876_0000_0000_0000, 0, 64'h10_0000, 8'h00, 64'h0, 64'h9876);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        ex_valid       = 1'b1;
        ex_mem_rd      = 1'b1;
        ex_mem_size    = 3'b010;
        ex_alu_result  = 64'h1002;
        ex_rd          = 5'd4;
        ex_is_write_rf = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL trap accept: stall=%b req=%b, required 0 0", mem_stall, dmem_req);
        end
        next_cycle();
        clear_ex();
        checks++;
        if (misalign_trap !== 1'b1 || dmem_req !== 1'b0 || fake_is_write_rf !== 1'b0) begin
            errors++;
            $display("FAIL trap: trap=%b req=%b we=%b, required 1 0 0", misalign_trap,
                     dmem_req, fake_is_write_rf);
        end
        next_cycle();
        checks++;
        if (misalign_trap !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL trap pulse: trap=%b req=%b, required 0 0", misalign_trap, dmem_req);
        end
`else
        do_mem("lw_misalign", 1'b1, 3'b010, 64'h1002, 64'h0, 5'd4, 1'b1,
               64'h1111_1111_2222_2222, 0, 64'h1000, 8'h00, 64'h0, 64'h2222_2222);
        checks++;
        if (misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL misalign_trap tie: %b, required 0", misalign_trap);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_delayed_ack();
        test_reset_mid_wait();
        test_back_to_back();
        test_misalign();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
